// File: rtl/plab3_mem_blocking_cache_ctrl.sv
// Control FSM for a 16-line direct-mapped, write-back, write-allocate blocking cache.
// Owns the per-line valid/dirty bits and every datapath enable; one request in flight at a time.
module plab3_mem_blocking_cache_ctrl #(
    parameter int p_idx_shamt    = 0,
    parameter int p_opaque_nbits = 8
) (
    input  logic        clk,
    input  logic        reset,

    // Handshakes: a transfer happens on a rising edge where val and rdy are both 1;
    // the sender holds val and its message stable until that edge.
    input  logic        cachereq_val,
    output logic        cachereq_rdy,
    output logic        cacheresp_val,
    input  logic        cacheresp_rdy,
    output logic        memreq_val,
    input  logic        memreq_rdy,
    input  logic        memresp_val,
    output logic        memresp_rdy,

    input  logic [2:0]  cachereq_type,
    input  logic [31:0] cachereq_addr,
    input  logic        tag_match,

    output logic [1:0]  amo_sel,
    output logic        cachereq_en,
    output logic        memresp_en,
    output logic        is_refill,
    output logic        tag_array_wen,
    output logic        tag_array_ren,
    output logic        data_array_wen,
    output logic        data_array_ren,
    output logic [15:0] data_array_wben,
    output logic        read_data_reg_en,
    output logic        read_tag_reg_en,
    output logic [1:0]  read_byte_sel,
    output logic [2:0]  memreq_type,
    output logic [2:0]  cacheresp_type,
    output logic [3:0]  dbg_state
);

    localparam int nblocks = 16;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        TC   = 4'd1,
        IN   = 4'd2,
        RD   = 4'd3,
        WD   = 4'd4,
        AR   = 4'd5,
        AW   = 4'd6,
        EP   = 4'd7,
        ER   = 4'd8,
        EW   = 4'd9,
        RR   = 4'd10,
        RW   = 4'd11,
        RU   = 4'd12,
        WT   = 4'd13
    } state_t;

    state_t             state;
    state_t             state_next;
    state_t             hit_dispatch;
    logic [nblocks-1:0] valid;
    logic [nblocks-1:0] dirty;
    logic [3:0]         idx;
    logic               hit;
    logic [15:0]        word_wben;
    logic [2:0]         amo_code;
    logic               unused_bits;

    assign idx         = cachereq_addr[4+p_idx_shamt +: 4];
    assign hit         = tag_match & valid[idx];
    assign word_wben   = 16'h000F << {cachereq_addr[3:2], 2'b00};
    assign amo_code    = cachereq_type - 3'd2;
    assign dbg_state   = state;
    assign unused_bits = ^{cachereq_addr, p_opaque_nbits[0]};

    // Where a request goes once its line is known to be present (hit or just refilled).
    always_comb begin
        case (cachereq_type)
            3'd0:             hit_dispatch = RD;
            3'd1:             hit_dispatch = WD;
            3'd3, 3'd4, 3'd5: hit_dispatch = AR;
            default:          hit_dispatch = RD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            case (state)
                IN, RU: begin
                    valid[idx] <= 1'b1;
                    dirty[idx] <= 1'b0;
                end
                WD, AW:  dirty[idx] <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cachereq_val) state_next = TC;
            TC: begin
                if (cachereq_type == 3'd2)        state_next = IN;
                else if (hit)                     state_next = hit_dispatch;
                else if (valid[idx] && dirty[idx]) state_next = EP;
                else                              state_next = RR;
            end
            IN, RD, WD, AW: state_next = WT;
            AR:             state_next = AW;
            EP:             state_next = ER;
            ER:   if (memreq_rdy)    state_next = EW;
            EW:   if (memresp_val)   state_next = RR;
            RR:   if (memreq_rdy)    state_next = RW;
            RW:   if (memresp_val)   state_next = RU;
            RU:                      state_next = hit_dispatch;
            WT:   if (cacheresp_rdy) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Moore decode; reset forces every output low, including the IDLE ready.
    always_comb begin
        cachereq_rdy     = 1'b0;
        cacheresp_val    = 1'b0;
        memreq_val       = 1'b0;
        memresp_rdy      = 1'b0;
        amo_sel          = 2'd0;
        cachereq_en      = 1'b0;
        memresp_en       = 1'b0;
        is_refill        = 1'b0;
        tag_array_wen    = 1'b0;
        tag_array_ren    = 1'b0;
        data_array_wen   = 1'b0;
        data_array_ren   = 1'b0;
        data_array_wben  = 16'h0000;
        read_data_reg_en = 1'b0;
        read_tag_reg_en  = 1'b0;
        read_byte_sel    = 2'd0;
        memreq_type      = 3'd0;
        cacheresp_type   = 3'd0;
        if (reset) begin
            read_byte_sel  = cachereq_addr[3:2];
            cacheresp_type = cachereq_type;
            case (state)
                IDLE: begin
                    cachereq_rdy = 1'b1;
                    cachereq_en  = cachereq_val;
                end
                TC: tag_array_ren = 1'b1;
                IN: begin
                    tag_array_wen   = 1'b1;
                    data_array_wen  = 1'b1;
                    data_array_wben = word_wben;
                end
                RD, AR: begin
                    data_array_ren   = 1'b1;
                    read_data_reg_en = 1'b1;
                end
                WD: begin
                    data_array_wen  = 1'b1;
                    data_array_wben = word_wben;
                end
                // read_data_reg keeps the pre-AMO word, which is what the response returns.
                AW: begin
                    data_array_wen  = 1'b1;
                    data_array_wben = word_wben;
                    amo_sel         = amo_code[1:0];
                end
                EP: begin
                    tag_array_ren    = 1'b1;
                    data_array_ren   = 1'b1;
                    read_tag_reg_en  = 1'b1;
                    read_data_reg_en = 1'b1;
                end
                ER: begin
                    memreq_val  = 1'b1;
                    memreq_type = 3'd1;
                end
                EW: memresp_rdy = 1'b1;
                RR: memreq_val = 1'b1;
                RW: begin
                    memresp_rdy = 1'b1;
                    memresp_en  = memresp_val;
                end
                RU: begin
                    is_refill       = 1'b1;
                    tag_array_wen   = 1'b1;
                    data_array_wen  = 1'b1;
                    data_array_wben = 16'hFFFF;
                end
                WT: cacheresp_val = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_plab3_mem_blocking_cache_ctrl.sv
// Bench for the blocking cache controller: emulates the tag comparator and memory,
// predicts memory traffic, array writes and response latency from a line-state model.
module tb_plab3_mem_blocking_cache_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        cachereq_val, cachereq_rdy, cacheresp_val, cacheresp_rdy;
    logic        memreq_val, memreq_rdy, memresp_val, memresp_rdy;
    logic [2:0]  cachereq_type;
    logic [31:0] cachereq_addr;
    logic        tag_match;
    logic [1:0]  amo_sel;
    logic        cachereq_en, memresp_en, is_refill;
    logic        tag_array_wen, tag_array_ren, data_array_wen, data_array_ren;
    logic [15:0] data_array_wben;
    logic        read_data_reg_en, read_tag_reg_en;
    logic [1:0]  read_byte_sel;
    logic [2:0]  memreq_type, cacheresp_type;
    logic [3:0]  dbg_state;

    plab3_mem_blocking_cache_ctrl dut (
        .clk(clk), .reset(reset),
        .cachereq_val(cachereq_val), .cachereq_rdy(cachereq_rdy),
        .cacheresp_val(cacheresp_val), .cacheresp_rdy(cacheresp_rdy),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
        .cachereq_type(cachereq_type), .cachereq_addr(cachereq_addr),
        .tag_match(tag_match), .amo_sel(amo_sel),
        .cachereq_en(cachereq_en), .memresp_en(memresp_en), .is_refill(is_refill),
        .tag_array_wen(tag_array_wen), .tag_array_ren(tag_array_ren),
        .data_array_wen(data_array_wen), .data_array_ren(data_array_ren),
        .data_array_wben(data_array_wben),
        .read_data_reg_en(read_data_reg_en), .read_tag_reg_en(read_tag_reg_en),
        .read_byte_sel(read_byte_sel), .memreq_type(memreq_type),
        .cacheresp_type(cacheresp_type), .dbg_state(dbg_state)
    );

    logic [38:0] out_vec;
    assign out_vec = {cachereq_rdy, cacheresp_val, memreq_val, memresp_rdy, amo_sel,
                      cachereq_en, memresp_en, is_refill, tag_array_wen, tag_array_ren,
                      data_array_wen, data_array_ren, data_array_wben, read_data_reg_en,
                      read_tag_reg_en, read_byte_sel, memreq_type, cacheresp_type};

    // Tag array stand-in: written whenever the controller asks, compared against the latched address.
    logic [23:0] dp_tag [16] = '{default: 24'h0};
    always @(posedge clk) if (tag_array_wen) dp_tag[cachereq_addr[7:4]] <= cachereq_addr[31:8];
    assign tag_match = (dp_tag[cachereq_addr[7:4]] == cachereq_addr[31:8]);

    // ---------------- scoreboard state ----------------
    logic [2:0]  exp_mreq_q[$];   // memreq_type per memory request
    logic [7:0]  exp_resp_q[$];   // {latency, type}
    logic [19:0] exp_wr_q[$];     // {is_refill, tag_wen, amo_sel, wben} per data write
    logic [7:0]  dly_q[$];        // {memreq_rdy delay, memresp delay}
    logic [3:0]  hold_q[$];       // cacheresp_rdy delay

    bit          m_valid [16];
    bit          m_dirty [16];
    logic [23:0] m_tag   [16];

    int n_cmp = 0;
    int n_err = 0;
    int resp_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got 0x%0h expected no event at %0t", name, act, $time);
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    // ---------------- memory responder ----------------
    logic [7:0] mem_dr;
    initial begin
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;
        forever begin
            if (reset && memreq_val) begin
                mem_dr = (dly_q.size() != 0) ? dly_q.pop_front() : 8'h00;
                repeat (int'(mem_dr[7:4])) begin @(posedge clk); #1; end
                memreq_rdy = 1'b1;
                @(posedge clk); #1;
                memreq_rdy = 1'b0;
                repeat (int'(mem_dr[3:0])) begin @(posedge clk); #1; end
                memresp_val = 1'b1;
                @(posedge clk); #1;
                memresp_val = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    // ---------------- response sink ----------------
    logic [3:0] resp_hold;
    initial begin
        cacheresp_rdy = 1'b0;
        forever begin
            if (reset && cacheresp_val) begin
                resp_hold = (hold_q.size() != 0) ? hold_q.pop_front() : 4'd0;
                repeat (int'(resp_hold)) begin @(posedge clk); #1; end
                cacheresp_rdy = 1'b1;
                @(posedge clk); #1;
                cacheresp_rdy = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    // ---------------- monitor ----------------
    bit          lat_run = 0;
    int          lat_cnt = 0;
    int          lat_seen = 0;
    bit          prev_mreq_stall = 0, prev_resp_stall = 0;
    logic [2:0]  prev_mreq_type, prev_resp_type;
    logic [3:0]  prev_state;
    logic [7:0]  e_resp;

    always @(negedge clk) begin
        if (!reset) begin
            lat_run = 0;
            prev_mreq_stall = 0;
            prev_resp_stall = 0;
        end else begin
            if (lat_run) begin
                lat_cnt++;
                if (cacheresp_val && lat_seen == 0) lat_seen = lat_cnt;
            end
            if (prev_mreq_stall) begin
                check("memreq_hold_val", memreq_val, 1);
                check("memreq_hold_type", memreq_type, prev_mreq_type);
                check("memreq_hold_state", dbg_state, prev_state);
            end
            if (prev_resp_stall) begin
                check("resp_hold_val", cacheresp_val, 1);
                check("resp_hold_type", cacheresp_type, prev_resp_type);
                check("resp_hold_state", dbg_state, prev_state);
            end
            if (memreq_val || memresp_rdy || cacheresp_val)
                check("cachereq_rdy_busy", cachereq_rdy, 0);
            if (memreq_val && memreq_rdy) begin
                if (exp_mreq_q.size() == 0) unexpected("memreq", memreq_type);
                else check("memreq_type", memreq_type, exp_mreq_q.pop_front());
            end
            if (data_array_wen) begin
                if (exp_wr_q.size() == 0) unexpected("data_write", data_array_wben);
                else check("data_write", {is_refill, tag_array_wen, amo_sel, data_array_wben},
                           exp_wr_q.pop_front());
            end
            if (cacheresp_val && cacheresp_rdy) begin
                if (exp_resp_q.size() == 0) begin
                    unexpected("cacheresp", cacheresp_type);
                end else begin
                    e_resp = exp_resp_q.pop_front();
                    check("resp_type", cacheresp_type, e_resp[2:0]);
                    check("resp_latency", lat_seen, e_resp[7:3]);
                end
                resp_cnt++;
                lat_run = 0;
            end
            if (cachereq_val && cachereq_rdy) begin
                lat_run  = 1;
                lat_cnt  = 0;
                lat_seen = 0;
            end
            prev_mreq_stall = memreq_val && !memreq_rdy;
            prev_resp_stall = cacheresp_val && !cacheresp_rdy;
            prev_mreq_type  = memreq_type;
            prev_resp_type  = cacheresp_type;
            prev_state      = dbg_state;
        end
    end

    // ---------------- driver: one request with its predicted outcome ----------------
    task automatic issue(input logic [2:0] t, input logic [31:0] a,
                         input int dlo, input int dhi, input int hlo, input int hhi);
        logic [3:0]  ix;
        logic [23:0] tg;
        logic [15:0] wb;
        logic [3:0]  d, r;
        logic [2:0]  amo;
        int          lat;
        int          target;
        ix = a[7:4];
        tg = a[31:8];
        wb = 16'hF << (4 * int'(a[3:2]));
        target = resp_cnt + 1;
        if (t == 3'd2) begin
            lat = 3;
            exp_wr_q.push_back({2'b01, 2'b00, wb});
            m_valid[ix] = 1;
            m_dirty[ix] = 0;
            m_tag[ix]   = tg;
        end else begin
            lat = (t >= 3'd3) ? 4 : 3;
            if (!(m_valid[ix] && m_tag[ix] == tg)) begin
                if (m_valid[ix] && m_dirty[ix]) begin
                    d = 4'($urandom_range(dhi, dlo));
                    r = 4'($urandom_range(dhi, dlo));
                    exp_mreq_q.push_back(3'd1);
                    dly_q.push_back({d, r});
                    lat += 1 + (int'(d) + 1) + (int'(r) + 1);
                end
                d = 4'($urandom_range(dhi, dlo));
                r = 4'($urandom_range(dhi, dlo));
                exp_mreq_q.push_back(3'd0);
                dly_q.push_back({d, r});
                lat += (int'(d) + 1) + (int'(r) + 1) + 1;
                exp_wr_q.push_back({2'b11, 2'b00, 16'hFFFF});
                m_valid[ix] = 1;
                m_dirty[ix] = 0;
                m_tag[ix]   = tg;
            end
            if (t == 3'd1) begin
                exp_wr_q.push_back({2'b00, 2'b00, wb});
                m_dirty[ix] = 1;
            end else if (t >= 3'd3) begin
                amo = t - 3'd2;
                exp_wr_q.push_back({2'b00, amo[1:0], wb});
                m_dirty[ix] = 1;
            end
        end
        exp_resp_q.push_back({5'(lat), t});
        hold_q.push_back(4'($urandom_range(hhi, hlo)));
        cachereq_type = t;
        cachereq_addr = a;
        cachereq_val  = 1'b1;
        @(posedge clk); #1;
        cachereq_val = 1'b0;
        for (int i = 0; i < 400 && resp_cnt < target; i++) begin
            @(posedge clk); #1;
        end
        if (resp_cnt < target) begin
            unexpected("resp_timeout", a);
            finish_run();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset         = 1'b0;
        cachereq_val  = 1'b0;
        cachereq_type = 3'd5;
        cachereq_addr = 32'h0000_000C;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
            m_tag[i]   = 24'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", out_vec, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_req_rdy", cachereq_rdy, 1);

        // init then read-hit, no memory traffic
        issue(3'd2, 32'h0000_0010, 0, 0, 0, 0);
        issue(3'd0, 32'h0000_0010, 0, 0, 0, 0);
        // cold read miss then hit
        issue(3'd0, 32'h0000_1004, 0, 2, 0, 1);
        issue(3'd0, 32'h0000_1004, 0, 0, 0, 0);
        // dirty line evicted by an aliasing read
        issue(3'd1, 32'h0000_0020, 0, 1, 0, 1);
        issue(3'd0, 32'h0000_0120, 0, 2, 0, 1);
        // AMOs on a resident line
        issue(3'd1, 32'h0000_0030, 0, 0, 0, 0);
        issue(3'd3, 32'h0000_0030, 0, 0, 0, 0);
        issue(3'd0, 32'h0000_0030, 0, 0, 0, 0);
        issue(3'd4, 32'h0000_0034, 0, 0, 0, 0);
        issue(3'd5, 32'h0000_0038, 0, 0, 0, 0);
        issue(3'd0, 32'h0000_0038, 0, 0, 0, 0);
        // long memory and response backpressure
        issue(3'd0, 32'h0000_2050, 7, 7, 10, 10);

        // reset while waiting for a refill response
        issue(3'd0, 32'h0000_0340, 0, 1, 0, 1);
        exp_mreq_q.push_back(3'd0);
        dly_q.push_back({4'd0, 4'd12});
        cachereq_type = 3'd1;
        cachereq_addr = 32'h0000_0750;
        cachereq_val  = 1'b1;
        @(posedge clk); #1;
        cachereq_val = 1'b0;
        for (int i = 0; i < 20 && !memresp_rdy; i++) begin
            @(posedge clk); #1;
        end
        check("reached_refill_wait", memresp_rdy, 1);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("midmiss_reset_handshakes", {cachereq_rdy, cacheresp_val, memreq_val, memresp_rdy}, 0);
        check("midmiss_reset_outputs", out_vec, 0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (memresp_val) check("stray_memresp_rdy", memresp_rdy, 0);
        end
        // line 4 still holds a matching tag, but its valid bit was cleared
        issue(3'd0, 32'h0000_0340, 0, 1, 0, 1);

        // randomized mix over a few conflicting lines
        for (int n = 0; n < 80; n++) begin
            logic [2:0]  t;
            logic [31:0] a;
            t = 3'($urandom_range(5, 0));
            a = {22'd0, 2'($urandom_range(3, 0)), 4'($urandom_range(3, 0)),
                 2'($urandom_range(3, 0)), 2'b00};
            issue(t, a, 0, 3, 0, 3);
        end

        repeat (3) @(posedge clk);
        #1;
        check("mreq_queue_drained", exp_mreq_q.size(), 0);
        check("resp_queue_drained", exp_resp_q.size(), 0);
        check("write_queue_drained", exp_wr_q.size(), 0);
        finish_run();
    end

endmodule
